// File: rtl/game_pkg.sv
// Shared encodings and field widths for the match-state core.
package game_pkg;

    localparam int SCORE_W = 4;
    localparam int SEC_W   = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PLAY = 2'b01,
        ST_OVER = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        WIN_NONE = 2'b00,
        WIN_P1   = 2'b01,
        WIN_P2   = 2'b10,
        WIN_TIE  = 2'b11
    } winner_t;

    function automatic winner_t decide_winner(input logic [SCORE_W-1:0] s1,
                                              input logic [SCORE_W-1:0] s2);
        if (s1 > s2)
            return WIN_P1;
        else if (s2 > s1)
            return WIN_P2;
        return WIN_TIE;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Purpose: prescaler emitting a one-cycle tick every CLK_HZ enabled cycles.
// Latency: tick is combinational on the terminal-count cycle.
// Backpressure: none; counter is held at 0 whenever en is low.
module tick_gen #(
    parameter int CLK_HZ = 100_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [CNT_W-1:0] TERM = CNT_W'(CLK_HZ - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (!en || cnt == TERM)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    assign tick = en && (cnt == TERM);

endmodule

// File: rtl/game_clock_score.sv
// Purpose: match timer, per-player scores and IDLE/PLAY/OVER sequencing.
// Latency: an input edge sampled on one clock is visible on outputs the next.
// Backpressure: none; level inputs are edge-detected, held levels fire once.
module game_clock_score
    import game_pkg::*;
#(
    parameter int CLK_HZ       = 100_000_000,
    parameter int GAME_SECONDS = 60,
    parameter int MAX_SCORE    = 9
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               goal1,
    input  logic               goal2,
    output logic [SCORE_W-1:0] score1,
    output logic [SCORE_W-1:0] score2,
    output logic [SEC_W-1:0]   seconds,
    output logic [1:0]         state,
    output logic [1:0]         winner
);

    localparam logic [SEC_W-1:0]   SEC_INIT  = SEC_W'(GAME_SECONDS);
    localparam logic [SCORE_W-1:0] SCORE_TOP = SCORE_W'(MAX_SCORE);

    logic    start_q, goal1_q, goal2_q;
    logic    start_ev, goal1_ev, goal2_ev;
    logic    play_en, tick;
    state_t  st;
    winner_t win;

    logic [SCORE_W-1:0] s1_nxt, s2_nxt;
    logic [SEC_W-1:0]   sec_nxt;
    logic               done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_q <= 1'b0;
            goal1_q <= 1'b0;
            goal2_q <= 1'b0;
        end else begin
            start_q <= start;
            goal1_q <= goal1;
            goal2_q <= goal2;
        end
    end

    assign start_ev = start & ~start_q;
    assign goal1_ev = goal1 & ~goal1_q;
    assign goal2_ev = goal2 & ~goal2_q;

    assign play_en = (st == ST_PLAY);

    tick_gen #(.CLK_HZ(CLK_HZ)) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (play_en),
        .tick (tick)
    );

    // Goals land before the end-of-match test, so a goal on the final tick counts.
    assign s1_nxt  = (goal1_ev && score1 < SCORE_TOP) ? score1 + 1'b1 : score1;
    assign s2_nxt  = (goal2_ev && score2 < SCORE_TOP) ? score2 + 1'b1 : score2;
    assign sec_nxt = (tick && seconds != '0) ? seconds - 1'b1 : seconds;
    assign done    = (sec_nxt == '0) || (s1_nxt == SCORE_TOP) || (s2_nxt == SCORE_TOP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st      <= ST_IDLE;
            win     <= WIN_NONE;
            score1  <= '0;
            score2  <= '0;
            seconds <= SEC_INIT;
        end else begin
            case (st)
                ST_IDLE, ST_OVER: begin
                    if (start_ev) begin
                        st      <= ST_PLAY;
                        win     <= WIN_NONE;
                        score1  <= '0;
                        score2  <= '0;
                        seconds <= SEC_INIT;
                    end
                end
                ST_PLAY: begin
                    score1  <= s1_nxt;
                    score2  <= s2_nxt;
                    seconds <= sec_nxt;
                    if (done) begin
                        st  <= ST_OVER;
                        win <= decide_winner(s1_nxt, s2_nxt);
                    end
                end
                default: st <= ST_IDLE;
            endcase
        end
    end

    assign state  = st;
    assign winner = win;

endmodule
